// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer. Counts down from a loaded value of at most 59:59.
// A one-cycle done pulse and a held alarm mark the step to 00:00.
// The alarm clears itself after ALARM_CYCLES clocks, or earlier on stop or load.
module countdown_timer #(
  parameter int ALARM_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start_resume,
  input  logic       stop,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  localparam logic [7:0] ALARM_INIT = 8'(ALARM_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [7:0] acnt_q, acnt_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       alarm_q, alarm_d;

  // decremented digit values and their borrows
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       b_so, b_st, b_mo;
  logic       cnt_zero, dec_zero, expire;

  function automatic logic [3:0] clamp_tens(input logic [3:0] v);
    return (v > 4'd5) ? 4'd5 : v;
  endfunction

  function automatic logic [3:0] clamp_ones(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Borrow chain: each digit moves only when every digit below it wraps.
  always_comb begin
    b_so   = (sec_ones_q == 4'd0);
    dec_so = b_so ? 4'd9 : sec_ones_q - 4'd1;
    b_st   = b_so && (sec_tens_q == 4'd0);
    dec_st = b_so ? ((sec_tens_q == 4'd0) ? 4'd5 : sec_tens_q - 4'd1) : sec_tens_q;
    b_mo   = b_st && (min_ones_q == 4'd0);
    dec_mo = b_st ? ((min_ones_q == 4'd0) ? 4'd9 : min_ones_q - 4'd1) : min_ones_q;
    dec_mt = (b_mo && (min_tens_q != 4'd0)) ? min_tens_q - 4'd1 : min_tens_q;
    cnt_zero = ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0000);
    dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      acnt_q     <= 8'd0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      acnt_q     <= acnt_d;
      running_q  <= running_d;
      done_q     <= done_d;
      alarm_q    <= alarm_d;
    end
  end

  // Next state, digits and alarm counter. Priority is load > stop > start_resume > tick.
  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    acnt_d     = acnt_q;
    expire     = 1'b0;
    if (load && (state_q != RUN)) begin
      min_tens_d = clamp_tens(load_min_tens);
      min_ones_d = clamp_ones(load_min_ones);
      sec_tens_d = clamp_tens(load_sec_tens);
      sec_ones_d = clamp_ones(load_sec_ones);
      state_d    = IDLE;
      acnt_d     = 8'd0;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (!stop && start_resume && !cnt_zero) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick && !cnt_zero) begin
            min_tens_d = dec_mt;
            min_ones_d = dec_mo;
            sec_tens_d = dec_st;
            sec_ones_d = dec_so;
            if (dec_zero) begin
              state_d = ALARM;
              acnt_d  = ALARM_INIT;
              expire  = 1'b1;
            end
          end
        end
        ALARM: begin
          if (stop || acnt_q <= 8'd1) begin
            state_d = IDLE;
            acnt_d  = 8'd0;
          end else begin
            acnt_d = acnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs, computed from the state being entered.
  always_comb begin
    running_d = (state_d == RUN);
    alarm_d   = (state_d == ALARM);
    done_d    = expire;
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = running_q;
  assign done     = done_q;
  assign alarm    = alarm_q;

endmodule
